// File: rtl/vga_readback.sv
// CPU pixel read responder: maps a packed (x,y) request to a framebuffer address, reads one colour, returns it.
// Latency RAM_LATENCY+1 edges from accept (1 edge for out-of-range); the response is held until start drops.
module vga_readback #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int RAM_LATENCY = 1,
  parameter int COLOUR_W    = 3,
  parameter int ADDR_W      = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                VGA_Select,
  input  logic [31:0]         data_in,
  output logic                ready,
  output logic [31:0]         data_out,
  output logic                err,
  output logic                fb_rd_en,
  output logic [ADDR_W-1:0]   fb_addr,
  input  logic [COLOUR_W-1:0] fb_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ready_d, err_d, fb_rd_en_d;
  logic [31:0]         data_out_d;
  logic [ADDR_W-1:0]   fb_addr_d;

  logic [7:0]          req_x;
  logic [6:0]          req_y;
  logic                in_range;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         rd_word;
  logic                unused_bits;

  assign req_x       = data_in[23:16];
  assign req_y       = data_in[30:24];
  assign unused_bits = ^{data_in[31], data_in[15:0]};

  assign in_range = (32'(req_x) < SCREEN_W) && (32'(req_y) < SCREEN_H);
  assign req_addr = ADDR_W'(req_y) * ADDR_W'(SCREEN_W) + ADDR_W'(req_x);

  // Response word echoes the coordinates alongside the colour.
  always_comb begin
    rd_word                 = '0;
    rd_word[30:24]          = y_q;
    rd_word[23:16]          = x_q;
    rd_word[COLOUR_W-1:0]   = fb_rd_data;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    ready_d    = ready;
    err_d      = err;
    data_out_d = data_out;
    fb_rd_en_d = 1'b0;
    fb_addr_d  = fb_addr;
    case (state_q)
      IDLE: begin
        if (start && VGA_Select) begin
          x_d = req_x;
          y_d = req_y;
          if (in_range) begin
            fb_addr_d  = req_addr;
            fb_rd_en_d = 1'b1;
            state_d    = ISSUE;
          end else begin
            err_d      = 1'b1;
            ready_d    = 1'b1;
            data_out_d = '0;
            state_d    = DONE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = 2'(RAM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          data_out_d = rd_word;
          ready_d    = 1'b1;
          err_d      = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        // Only start matters here; a held start keeps the response up.
        if (!start) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      ready    <= ready_d;
      err      <= err_d;
      data_out <= data_out_d;
      fb_rd_en <= fb_rd_en_d;
      fb_addr  <= fb_addr_d;
    end
  end

endmodule

// File: tb/tb_vga_readback.sv
// Directed bench for vga_readback: one instance at RAM_LATENCY=1, one at RAM_LATENCY=3, each with a RAM model.
module tb_vga_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_sel;
  logic [31:0] data_in;
  logic        start1, start3;

  logic        ready1, ready3, err1, err3, rd_en1, rd_en3;
  logic [31:0] dout1, dout3;
  logic [14:0] addr1, addr3;
  logic [2:0]  rdata1, rdata3;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt1  = 0;
  int rd_cnt3  = 0;

  always #5 clk = ~clk;

  vga_readback #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .VGA_Select(vga_sel), .data_in(data_in),
    .ready(ready1), .data_out(dout1), .err(err1), .fb_rd_en(rd_en1), .fb_addr(addr1),
    .fb_rd_data(rdata1)
  );

  vga_readback #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .VGA_Select(vga_sel), .data_in(data_in),
    .ready(ready3), .data_out(dout3), .err(err3), .fb_rd_en(rd_en3), .fb_addr(addr3),
    .fb_rd_data(rdata3)
  );

  // Framebuffer contents: colour = low 3 address bits xor 3'b010.
  logic [2:0] mem [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'(i) ^ 3'b010;
  end

  logic [2:0] s0, s1, s2;
  always @(posedge clk) begin
    if (rd_en1) rdata1 <= mem[addr1];
    if (rd_en3) s0 <= mem[addr3];
    s1 <= s0;
    s2 <= s1;
    if (rd_en1) rd_cnt1 <= rd_cnt1 + 1;
    if (rd_en3) rd_cnt3 <= rd_cnt3 + 1;
  end
  assign rdata3 = s2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vga_sel = 1'b1; data_in = 32'h0; start1 = 1'b0; start3 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++; if (fb_or(addr1, addr3) !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d/%0d want 0", addr1, addr3); end
    n_checks++; if ({err1, err3} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {err1, err3}); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({ready1, ready3, rd_en1, rd_en3} !== 4'b0 || dout1 !== 32'h0 || dout3 !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: ready=%b%b rd_en=%b%b dout=%h/%h want all 0", i, ready1, ready3, rd_en1, rd_en3, dout1, dout3);
      end
      tick();
    end
  endtask

  function automatic logic [14:0] fb_or(input logic [14:0] a, input logic [14:0] b);
    return a | b;
  endfunction

  task automatic test_max_pixel;
    int c0;
    c0 = rd_cnt1;
    data_in = 32'h779F0000; start1 = 1'b1;
    tick();  // E0 accept
    data_in = 32'h12345678;
    n_checks++; if (rd_en1 !== 1'b1 || addr1 !== 15'd19199) begin n_fail++; $display("FAIL max_issue: rd_en=%b addr=%0d want 1/19199", rd_en1, addr1); end
    n_checks++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL max_ready_e0: got %b want 0", ready1); end
    tick();  // E1
    n_checks++; if (rd_en1 !== 1'b0 || ready1 !== 1'b0 || addr1 !== 15'd19199) begin n_fail++; $display("FAIL max_wait: rd_en=%b ready=%b addr=%0d want 0/0/19199", rd_en1, ready1, addr1); end
    tick();  // E2
    n_checks++; if (ready1 !== 1'b1 || err1 !== 1'b0) begin n_fail++; $display("FAIL max_ready_e2: ready=%b err=%b want 1/0", ready1, err1); end
    n_checks++; if (dout1 !== 32'h779F0005) begin n_fail++; $display("FAIL max_data: got %h want 779f0005", dout1); end
    tick();
    n_checks++; if (ready1 !== 1'b1 || dout1 !== 32'h779F0005) begin n_fail++; $display("FAIL max_hold: ready=%b dout=%h want 1/779f0005", ready1, dout1); end
    start1 = 1'b0;
    tick();
    n_checks++; if (ready1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL max_release: ready=%b err=%b want 0/0", ready1, err1); end
    n_checks++; if (dout1 !== 32'h779F0005) begin n_fail++; $display("FAIL max_keep_data: got %h want 779f0005", dout1); end
    n_checks++; if (rd_cnt1 - c0 !== 1) begin n_fail++; $display("FAIL max_rd_pulses: got %0d want 1", rd_cnt1 - c0); end
    tick();
  endtask

  task automatic test_out_of_range;
    int c0;
    c0 = rd_cnt1;
    data_in = 32'h00A00000; start1 = 1'b1;
    tick();  // E0
    n_checks++; if (ready1 !== 1'b1 || err1 !== 1'b1) begin n_fail++; $display("FAIL oor_resp: ready=%b err=%b want 1/1", ready1, err1); end
    n_checks++; if (dout1 !== 32'h0 || rd_en1 !== 1'b0) begin n_fail++; $display("FAIL oor_data: dout=%h rd_en=%b want 0/0", dout1, rd_en1); end
    start1 = 1'b0;
    tick();
    n_checks++; if (ready1 !== 1'b0 || err1 !== 1'b0) begin n_fail++; $display("FAIL oor_release: ready=%b err=%b want 0/0", ready1, err1); end
    n_checks++; if (rd_cnt1 - c0 !== 0) begin n_fail++; $display("FAIL oor_rd_pulses: got %0d want 0", rd_cnt1 - c0); end
    data_in = 32'h78000000; start1 = 1'b1;  // y=120, x=0
    tick();
    n_checks++; if (ready1 !== 1'b1 || err1 !== 1'b1 || rd_en1 !== 1'b0) begin n_fail++; $display("FAIL oor_y: ready=%b err=%b rd_en=%b want 1/1/0", ready1, err1, rd_en1); end
    start1 = 1'b0;
    tick();
  endtask

  task automatic test_latency3;
    data_in = 32'h02050000; start3 = 1'b1;
    tick();  // E0
    n_checks++; if (rd_en3 !== 1'b1 || addr3 !== 15'd325) begin n_fail++; $display("FAIL lat3_issue: rd_en=%b addr=%0d want 1/325", rd_en3, addr3); end
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++; if (ready3 !== 1'b0 || rd_en3 !== 1'b0) begin n_fail++; $display("FAIL lat3_early_e%0d: ready=%b rd_en=%b want 0/0", e, ready3, rd_en3); end
    end
    tick();  // E4
    n_checks++; if (ready3 !== 1'b1 || err3 !== 1'b0) begin n_fail++; $display("FAIL lat3_ready_e4: ready=%b err=%b want 1/0", ready3, err3); end
    n_checks++; if (dout3 !== 32'h02050007) begin n_fail++; $display("FAIL lat3_data: got %h want 02050007", dout3); end
    start3 = 1'b0;
    tick();
  endtask

  task automatic test_early_drop;
    data_in = 32'h01000000; start3 = 1'b1;  // y=1, x=0 -> addr 160
    tick();  // E0
    start3 = 1'b0;
    n_checks++; if (addr3 !== 15'd160) begin n_fail++; $display("FAIL drop_addr: got %0d want 160", addr3); end
    tick(); tick(); tick();
    n_checks++; if (ready3 !== 1'b0) begin n_fail++; $display("FAIL drop_early: ready=%b want 0", ready3); end
    tick();  // E4
    n_checks++; if (ready3 !== 1'b1 || dout3 !== 32'h01000002) begin n_fail++; $display("FAIL drop_resp: ready=%b dout=%h want 1/01000002", ready3, dout3); end
    tick();
    n_checks++; if (ready3 !== 1'b0 || dout3 !== 32'h01000002) begin n_fail++; $display("FAIL drop_pulse: ready=%b dout=%h want 0/01000002", ready3, dout3); end
  endtask

  task automatic test_no_select;
    int c1, c3;
    c1 = rd_cnt1; c3 = rd_cnt3;
    vga_sel = 1'b0; data_in = 32'h779F0000; start1 = 1'b1; start3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({ready1, ready3, rd_en1, rd_en3} !== 4'b0) begin
        n_fail++; $display("FAIL nosel_cycle%0d: ready=%b%b rd_en=%b%b want 0", i, ready1, ready3, rd_en1, rd_en3);
      end
    end
    n_checks++; if (rd_cnt1 - c1 !== 0 || rd_cnt3 - c3 !== 0) begin n_fail++; $display("FAIL nosel_pulses: got %0d/%0d want 0/0", rd_cnt1 - c1, rd_cnt3 - c3); end
    start1 = 1'b0; start3 = 1'b0; vga_sel = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = rd_cnt1;
    data_in = 32'h04030000; start1 = 1'b1;  // y=4, x=3 -> addr 643
    tick(); tick(); tick();
    n_checks++; if (ready1 !== 1'b1 || dout1 !== 32'h04030001) begin n_fail++; $display("FAIL b2b_first: ready=%b dout=%h want 1/04030001", ready1, dout1); end
    data_in = 32'h00010000;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (ready1 !== 1'b1 || rd_cnt1 - c0 !== 1) begin n_fail++; $display("FAIL b2b_held: ready=%b pulses=%0d want 1/1", ready1, rd_cnt1 - c0); end
    start1 = 1'b0;
    tick();
    n_checks++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: ready=%b want 0", ready1); end
    start1 = 1'b1;  // y=0, x=1 -> addr 1
    tick();
    n_checks++; if (rd_en1 !== 1'b1 || addr1 !== 15'd1) begin n_fail++; $display("FAIL b2b_issue2: rd_en=%b addr=%0d want 1/1", rd_en1, addr1); end
    tick(); tick();
    n_checks++; if (ready1 !== 1'b1 || dout1 !== 32'h00010003) begin n_fail++; $display("FAIL b2b_second: ready=%b dout=%h want 1/00010003", ready1, dout1); end
    start1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    data_in = 32'h02050000; start3 = 1'b1;
    tick();  // E0 -> ISSUE
    tick();  // E1 -> WAIT
    rst_n = 1'b0; start3 = 1'b0;
    tick();
    n_checks++; if (ready3 !== 1'b0 || rd_en3 !== 1'b0 || addr3 !== 15'd0) begin n_fail++; $display("FAIL rst_mid: ready=%b rd_en=%b addr=%0d want 0/0/0", ready3, rd_en3, addr3); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (ready3 !== 1'b0 || dout3 !== 32'h0) begin n_fail++; $display("FAIL rst_no_resp%0d: ready=%b dout=%h want 0/0", i, ready3, dout3); end
    end
    data_in = 32'h779F0000; start3 = 1'b1;
    tick();
    n_checks++; if (rd_en3 !== 1'b1 || addr3 !== 15'd19199) begin n_fail++; $display("FAIL rst_after_issue: rd_en=%b addr=%0d want 1/19199", rd_en3, addr3); end
    tick(); tick(); tick(); tick();
    n_checks++; if (ready3 !== 1'b1 || dout3 !== 32'h779F0005 || err3 !== 1'b0) begin n_fail++; $display("FAIL rst_after_resp: ready=%b dout=%h err=%b want 1/779f0005/0", ready3, dout3, err3); end
    start3 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_max_pixel();
    test_out_of_range();
    test_latency3();
    test_early_drop();
    test_no_select();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
